// File: rtl/count_mode_controller.sv
// Run-length controlled counter: counts N steps in one of four latched modes,
// then pulses done. A stop request ends a run early and flags aborted.
module count_mode_controller #(
    parameter int DIGITS = 4,
    parameter int MAX    = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [7:0]        cycles,
    output logic [DIGITS-1:0] count,
    output logic              dir,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [DIGITS-1:0] TOP  = DIGITS'(MAX - 1);
    localparam logic [DIGITS-1:0] TOP1 = DIGITS'(MAX - 2);
    localparam logic [DIGITS-1:0] ONE  = DIGITS'(1);

    state_t            state_q, state_d;
    logic [DIGITS-1:0] count_q, count_d;
    logic              dir_q, dir_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic [1:0]        mode_q, mode_d;
    logic [7:0]        remaining_q, remaining_d;

    logic [DIGITS-1:0] adv_count;
    logic              adv_dir;

    // One count step in the latched mode.
    always_comb begin
        adv_count = count_q;
        adv_dir   = dir_q;
        case (mode_q)
            2'b00: adv_count = (count_q == TOP) ? '0 : count_q + ONE;
            2'b01: adv_count = {~count_q[0], count_q[DIGITS-1:1]};
            2'b10: begin
                if (!dir_q) begin
                    if (count_q == TOP) begin
                        adv_dir   = 1'b1;
                        adv_count = TOP1;
                    end else begin
                        adv_count = count_q + ONE;
                    end
                end else begin
                    if (count_q == '0) begin
                        adv_dir   = 1'b0;
                        adv_count = ONE;
                    end else begin
                        adv_count = count_q - ONE;
                    end
                end
            end
            default: adv_count = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        dir_d       = dir_q;
        aborted_d   = aborted_q;
        mode_d      = mode_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d     = '0;
                    dir_d       = 1'b0;
                    aborted_d   = 1'b0;
                    mode_d      = mode;
                    remaining_d = cycles;
                    state_d     = (cycles != 8'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                // The final step takes precedence over a simultaneous stop.
                if (remaining_q == 8'd1) begin
                    count_d     = adv_count;
                    dir_d       = adv_dir;
                    remaining_d = 8'd0;
                    state_d     = DONE;
                end else if (stop) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    count_d     = adv_count;
                    dir_d       = adv_dir;
                    remaining_d = remaining_q - 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            mode_q      <= 2'b00;
            remaining_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            dir_q       <= dir_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            mode_q      <= mode_d;
            remaining_q <= remaining_d;
        end
    end

    assign count   = count_q;
    assign dir     = dir_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;

endmodule

// File: doc/count_mode_controller.md
COUNT_MODE_CONTROLLER -- requirements
Module: count_mode_controller

Interface
REQ-001 Parameter DIGITS, default 4: width of the count register.
REQ-002 Parameter MAX, default 16: binary/bounce modulus; legal range 2 to 2**DIGITS.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 stop  input  1  abort request; sampled only in RUN.
REQ-007 mode  input  2  counting mode, latched at start: 00 binary up, 01 Johnson shift, 10 bounce, 11 hold.
REQ-008 cycles  input  8  run length in count steps, latched at start.
REQ-009 count  output  DIGITS  current count value (registered).
REQ-010 dir  output  1  bounce direction (0 up, 1 down); 0 in all other modes.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  single-cycle pulse in DONE.
REQ-013 aborted  output  1  high with done when the run ended by stop; holds until next start.

Function
REQ-014 FSM states are IDLE, RUN and DONE; encoding is free; no other reachable states.
REQ-015 IDLE with start=1 at an edge: count<=0, dir<=0, aborted<=0, mode and cycles latched, remaining<=cycles.
REQ-016 On that edge: next state is RUN if cycles!=0, else DONE (zero-length run, count stays 0).
REQ-017 IDLE with start=0: all registers hold; count keeps the last run's final value.
REQ-018 In RUN, each edge advances count once per latched mode and decrements remaining by 1.
REQ-019 In RUN with remaining==1 at an edge: the final advance occurs and next state is DONE.
REQ-020 Run length: for cycles=N>0, busy is high exactly N cycles, count advances exactly N times, done follows the last busy cycle.
REQ-021 Binary mode: count<=count+1; count==MAX-1 wraps to 0.
REQ-022 Johnson mode: count<={~count[0], count[DIGITS-1:1]}; period 2*DIGITS from 0 (DIGITS=4: 0,8,C,E,F,7,3,1,0).
REQ-023 Bounce mode, dir=0: count+1; at count==MAX-1, dir<=1 and count<=MAX-2.
REQ-024 Bounce mode, dir=1: count-1; at count==0, dir<=0 and count<=1 (sequence 0..MAX-1..0..1, no repeated endpoint).
REQ-025 Hold mode: count unchanged; remaining still decrements.
REQ-026 stop=1 in RUN with remaining>1: no count advance on that edge, aborted<=1, next state DONE.
REQ-027 stop=1 coinciding with remaining==1: natural completion wins; the final advance occurs and aborted stays 0.
REQ-028 DONE lasts exactly one cycle (done=1), then IDLE unconditionally; start in DONE is ignored.
REQ-029 start while busy or in DONE is ignored; stop in IDLE or DONE is ignored.
REQ-030 Latched mode/cycles are immune to input changes during RUN.
REQ-031 Back-to-back runs: start in the IDLE cycle right after DONE is accepted; minimum spacing is N+2 cycles per run.

Reset
REQ-032 reset_n=0 at an edge: state<=IDLE, count<=0, dir<=0, busy=0, done=0, aborted=0, remaining<=0.
REQ-033 reset_n has priority over start, stop and any in-progress run; a mid-RUN reset produces no done pulse.
REQ-034 All outputs are registered and take their reset values from the first edge with reset_n=0.

Verification
REQ-035 Binary, MAX=16, cycles=20 -> busy 20 cycles; count 1..15,0,1..4; final count 4; done 1 cycle; aborted=0.
REQ-036 Johnson, cycles=9 -> count 8,C,E,F,7,3,1,0,8; final count 8.
REQ-037 Bounce, MAX=4, cycles=8 -> count 1,2,3,2,1,0,1,2; dir goes 1 after count 3 and 0 after count 0.
REQ-038 Binary, cycles=10, stop on 4th busy cycle -> count frozen at 3; done with aborted=1; busy total 4 cycles.
REQ-039 cycles=0 -> busy never high; done the cycle after start; count=0. Second start during RUN is ignored; stop coincident with the last step gives aborted=0.
REQ-040 reset_n=0 on 5th RUN cycle of a 10-step run -> next cycle IDLE, count=0, no done pulse; a new start then runs normally.
